// File: rtl/autorange_ctrl.sv
// Measurement sequencer and auto-ranging controller: settle -> measure -> evaluate,
// steps the regime on overflow / sustained under-range, aborts stalled measurements.
module autorange_ctrl #(
  parameter int unsigned NUM_REGIMES    = 6,
  parameter int unsigned SETTLE_CYCLES  = 200,
  parameter int unsigned TIMEOUT_CYCLES = 20000000,
  parameter int unsigned CNT_W          = 25,
  parameter int unsigned HYST_COUNT     = 2
) (
  input  logic       clk_200MHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       auto_mode,
  input  logic [2:0] manual_regime,
  input  logic       meas_done,
  input  logic       meas_overflow,
  input  logic       meas_underrange,
  output logic [2:0] regime,
  output logic       access,
  output logic       busy,
  output logic       result_valid,
  output logic       range_changed,
  output logic       timeout,
  output logic       over_range
);

  localparam int unsigned REG_W = 3;
  localparam int unsigned LOW_W = 3;
  localparam logic [REG_W-1:0] TOP_REGIME = REG_W'(NUM_REGIMES - 1);
  localparam logic [LOW_W-1:0] HYST       = LOW_W'(HYST_COUNT);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_END    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EVAL} state_t;

  state_t           state, state_n;
  logic [REG_W-1:0] regime_n, man_regime;
  logic [REG_W-1:0] pend_regime, pend_regime_n;
  logic [LOW_W-1:0] low_cnt, low_cnt_n, low_inc;
  logic [LOW_W-1:0] pend_low, pend_low_n;
  logic             pend_settle, pend_settle_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             result_valid_n, range_changed_n, timeout_n, over_range_n;
  logic             man_change;

  // Evaluation is decided when meas_done arrives so its pulses are visible during EVAL;
  // the resulting regime/low_cnt/next-state decision is held in pend_* and applied leaving EVAL.
  always_comb begin
    state_n         = state;
    regime_n        = regime;
    cnt_n           = cnt;
    low_cnt_n       = auto_mode ? low_cnt : '0;
    pend_regime_n   = pend_regime;
    pend_low_n      = pend_low;
    pend_settle_n   = pend_settle;
    over_range_n    = over_range;
    result_valid_n  = 1'b0;
    range_changed_n = 1'b0;
    timeout_n       = 1'b0;

    man_regime = (manual_regime > TOP_REGIME) ? TOP_REGIME : manual_regime;
    man_change = !auto_mode && (man_regime != regime) && (state != IDLE);
    low_inc    = (low_cnt >= HYST) ? HYST : low_cnt + LOW_W'(1);

    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (man_change) begin
      regime_n        = man_regime;
      range_changed_n = 1'b1;
      cnt_n           = '0;
      state_n         = SETTLE;
    end else begin
      unique case (state)
        IDLE: begin
          regime_n = auto_mode ? regime : man_regime;
          cnt_n    = '0;
          state_n  = SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_END) begin
            cnt_n   = '0;
            state_n = MEASURE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        MEASURE: begin
          if (meas_done) begin
            state_n       = EVAL;
            cnt_n         = '0;
            pend_regime_n = regime;
            pend_low_n    = low_cnt;
            pend_settle_n = 1'b0;
            if (!auto_mode) begin
              over_range_n   = meas_overflow;
              result_valid_n = 1'b1;
              pend_low_n     = '0;
            end else if (meas_overflow) begin
              if (regime < TOP_REGIME) begin
                pend_regime_n   = regime + REG_W'(1);
                pend_low_n      = '0;
                pend_settle_n   = 1'b1;
                range_changed_n = 1'b1;
              end else begin
                over_range_n   = 1'b1;
                result_valid_n = 1'b1;
              end
            end else if (meas_underrange) begin
              if ((low_inc == HYST) && (regime != '0)) begin
                pend_regime_n   = regime - REG_W'(1);
                pend_low_n      = '0;
                pend_settle_n   = 1'b1;
                range_changed_n = 1'b1;
              end else begin
                pend_low_n     = low_inc;
                result_valid_n = 1'b1;
              end
            end else begin
              pend_low_n     = '0;
              over_range_n   = 1'b0;
              result_valid_n = 1'b1;
            end
          end else if (cnt == TMO_END) begin
            timeout_n = 1'b1;
            cnt_n     = '0;
            state_n   = SETTLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        EVAL: begin
          regime_n  = pend_regime;
          low_cnt_n = auto_mode ? pend_low : '0;
          cnt_n     = '0;
          state_n   = pend_settle ? SETTLE : MEASURE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_200MHz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      regime        <= '0;
      cnt           <= '0;
      low_cnt       <= '0;
      pend_regime   <= '0;
      pend_low      <= '0;
      pend_settle   <= 1'b0;
      access        <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      range_changed <= 1'b0;
      timeout       <= 1'b0;
      over_range    <= 1'b0;
    end else begin
      state         <= state_n;
      regime        <= regime_n;
      cnt           <= cnt_n;
      low_cnt       <= low_cnt_n;
      pend_regime   <= pend_regime_n;
      pend_low      <= pend_low_n;
      pend_settle   <= pend_settle_n;
      access        <= (state_n == MEASURE);
      busy          <= (state_n != IDLE);
      result_valid  <= result_valid_n;
      range_changed <= range_changed_n;
      timeout       <= timeout_n;
      over_range    <= over_range_n;
    end
  end

endmodule

// File: tb/tb_autorange_ctrl.sv
// Directed bench for autorange_ctrl: a per-cycle vector table for auto-ranging plus
// hand sequences for timeout, manual regime changes, disable and asynchronous reset.
module tb_autorange_ctrl;

  logic       clk_200MHz = 1'b0;
  logic       reset, enable, auto_mode, meas_done, meas_overflow, meas_underrange;
  logic [2:0] manual_regime, regime;
  logic       access, busy, result_valid, range_changed, timeout, over_range;

  autorange_ctrl #(
    .NUM_REGIMES(6), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_W(25), .HYST_COUNT(2)
  ) dut (
    .clk_200MHz(clk_200MHz), .reset(reset), .enable(enable), .auto_mode(auto_mode),
    .manual_regime(manual_regime), .meas_done(meas_done), .meas_overflow(meas_overflow),
    .meas_underrange(meas_underrange), .regime(regime), .access(access), .busy(busy),
    .result_valid(result_valid), .range_changed(range_changed), .timeout(timeout),
    .over_range(over_range)
  );

  always #5 clk_200MHz = ~clk_200MHz;

  // exp = {regime[2:0], access, busy, result_valid, range_changed, timeout, over_range}
  typedef struct {
    logic       en, au;
    logic [2:0] mr;
    logic       dn, ov, un;
    logic [8:0] exp;
  } vec_t;

  vec_t       vq[$];
  logic       cur_en, cur_au;
  logic [2:0] cur_mr;
  int         total = 0;
  int         bad   = 0;

  function automatic void add(input logic dn, ov, un, input logic [2:0] r,
                              input logic acc, bz, rv, rc, to, ovr);
    vec_t v;
    v.en = cur_en; v.au = cur_au; v.mr = cur_mr;
    v.dn = dn; v.ov = ov; v.un = un;
    v.exp = {r, acc, bz, rv, rc, to, ovr};
    vq.push_back(v);
  endfunction

  // SETTLE entry plus three more dead cycles, then access rises
  function automatic void settle(input logic [2:0] r, input logic ovr);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ovr);
    add(1'b0, 1'b0, 1'b0, r, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ovr);
  endfunction

  function automatic logic [8:0] outs();
    return {regime, access, busy, result_valid, range_changed, timeout, over_range};
  endfunction

  task automatic step();
    @(posedge clk_200MHz);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got reg=%0d acc/busy/rv/rc/to/or=%b want reg=%0d acc/busy/rv/rc/to/or=%b",
               name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
    end
  endtask

  task automatic drive(input logic dn, ov, un);
    meas_done = dn; meas_overflow = ov; meas_underrange = un;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; auto_mode = 1'b1; manual_regime = 3'd0;
    drive(1'b0, 1'b0, 1'b0);

    // ---- vector table ----
    cur_en = 1'b1; cur_au = 1'b1; cur_mr = 3'd0;
    settle(3'd0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      add(1'b1, 1'b1, 1'b0, 3'(r), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      settle(3'(r + 1), 1'b0);
    end
    add(1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);  // overflow at top
    add(1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // back-to-back MEASURE
    add(1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // normal clears over_range
    add(1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // under-range #1
    add(1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // under-range #2 steps down
    settle(3'd4, 1'b0);
    add(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle(3'd3, 1'b0);
    add(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // under, normal, under: no step
    add(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // both flags: overflow wins
    settle(3'd4, 1'b0);
    cur_en = 1'b0;
    add(1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // disable mid-MEASURE
    add(1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur_en = 1'b1;
    for (int k = 0; k < 4; k++)                                         // meas_done ignored outside MEASURE
      add(1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset ----
    step(); step();
    check("reset_state", outs(), 9'd0);
    reset = 1'b0;
    step();
    check("idle_after_reset", outs(), 9'd0);

    foreach (vq[i]) begin
      enable = vq[i].en; auto_mode = vq[i].au; manual_regime = vq[i].mr;
      drive(vq[i].dn, vq[i].ov, vq[i].un);
      step();
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
    end
    drive(1'b0, 1'b0, 1'b0);

    // ---- timeout: MEASURE at regime 4, counter at 0 ----
    repeat (15) step();
    check("tmo_still_measuring", outs(), {3'd4, 6'b110000});
    step();
    check("tmo_pulse", outs(), {3'd4, 6'b010010});
    step();
    check("tmo_pulse_end", outs(), {3'd4, 6'b010000});
    repeat (2) step();
    step();
    check("tmo_resettled", outs(), {3'd4, 6'b110000});
    repeat (15) step();
    drive(1'b1, 1'b0, 1'b0);
    step();
    check("done_beats_tmo", outs(), {3'd4, 6'b011000});
    drive(1'b0, 1'b0, 1'b0);
    step();
    check("eval_to_measure", outs(), {3'd4, 6'b110000});

    // ---- manual mode ----
    auto_mode = 1'b0; manual_regime = 3'd7;
    step();
    check("man_clamp", outs(), {3'd5, 6'b010100});
    repeat (3) step();
    step();
    check("man_settled", outs(), {3'd5, 6'b110000});
    manual_regime = 3'd2;
    drive(1'b1, 1'b0, 1'b0);
    step();
    check("man_change_discard", outs(), {3'd2, 6'b010100});
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    step();
    check("man_resettled", outs(), {3'd2, 6'b110000});
    drive(1'b1, 1'b0, 1'b1);
    step();
    check("man_under_nostep", outs(), {3'd2, 6'b011000});
    drive(1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0);
    step();
    check("man_overflow", outs(), {3'd2, 6'b011001});
    drive(1'b0, 1'b0, 1'b0);
    manual_regime = 3'd4;
    step();
    check("man_to_4", outs(), {3'd4, 6'b010101});
    repeat (3) step();
    step();
    check("man_4_measure", outs(), {3'd4, 6'b110001});

    // ---- disable then async reset mid-MEASURE ----
    enable = 1'b0;
    step();
    check("disable_retain", outs(), {3'd4, 6'b000001});
    enable = 1'b1;
    repeat (4) step();
    step();
    check("reenable_measure", outs(), {3'd4, 6'b110001});
    #2 reset = 1'b1;
    #1;
    check("async_reset", outs(), 9'd0);
    step();
    check("reset_held", outs(), 9'd0);
    enable = 1'b0;
    reset  = 1'b0;
    step();
    check("post_reset_idle", outs(), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
